// File: rtl/btn_cond.sv
// btn_cond: multi-channel push-button conditioner.
//
// Each channel synchronizes its raw button level, debounces it, and derives
// edge pulses plus long-press / auto-repeat indications from the clean level.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   rst          synchronous active-high reset
//   btn_raw      asynchronous bouncing button levels, active-high
//   btn_level    debounced button level
//   btn_press    one-cycle pulse on each debounced rising edge
//   btn_release  one-cycle pulse on each debounced falling edge
//   btn_repeat   one-cycle auto-repeat pulses while a button is held
//   btn_long     high while a button has been held for at least HOLD_MS
module btn_cond #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int N_BTN       = 5,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int HOLD_CYC = CLK_FREQ / 1000 * HOLD_MS;
    localparam int REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;

    // Reject parameter sets whose timing constants collapse to zero cycles.
    if (DB_CYC < 1) begin : g_bad_db
        $error("btn_cond: debounce time is shorter than one clock cycle");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("btn_cond: hold time is shorter than one clock cycle");
    end
    if (REP_CYC < 1) begin : g_bad_rep
        $error("btn_cond: repeat period is shorter than one clock cycle");
    end

    localparam int HR_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int DB_W   = $clog2(DB_CYC) + 1;
    localparam int HR_W   = $clog2(HR_MAX) + 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC);
    localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYC - 1);
    localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    // Two-flop synchronizer stages.
    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;

    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [HR_W-1:0]  hr_cnt [N_BTN];
    state_t           state  [N_BTN];

    logic [N_BTN-1:0] differ;
    logic [N_BTN-1:0] db_done;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;

    // A channel's level flips on the edge where its disagreement counter has
    // already reached DB_CYC and the synchronized value still disagrees.
    always_comb begin
        differ  = sync_p1 ^ btn_level;
        db_done = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_done[i] = differ[i] && (db_cnt[i] == DB_LAST);
        end
        rise = db_done & sync_p1;
        fall = db_done & ~sync_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
            btn_long    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
                hr_cnt[i] <= '0;
                state[i]  <= IDLE;
            end
        end else begin
            // synchronizer -> debounce boundary
            sync_p0     <= btn_raw;
            sync_p1     <= sync_p0;
            btn_press   <= rise;
            btn_release <= fall;

            for (int i = 0; i < N_BTN; i++) begin
                // Debounce: count consecutive disagreement, clear on agreement.
                if (!differ[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_done[i]) begin
                    db_cnt[i]    <= '0;
                    btn_level[i] <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end

                // Hold / repeat FSM; a release in the same cycle as a due
                // repeat pulse wins, so the repeat is never emitted.
                btn_repeat[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        btn_long[i] <= 1'b0;
                        if (rise[i]) begin
                            state[i]  <= HELD;
                            hr_cnt[i] <= '0;
                        end
                    end
                    HELD: begin
                        if (fall[i]) begin
                            state[i]    <= IDLE;
                            hr_cnt[i]   <= '0;
                            btn_long[i] <= 1'b0;
                        end else if (hr_cnt[i] == HOLD_LAST) begin
                            state[i]      <= REPEAT;
                            hr_cnt[i]     <= '0;
                            btn_long[i]   <= 1'b1;
                            btn_repeat[i] <= 1'b1;
                        end else begin
                            hr_cnt[i] <= hr_cnt[i] + HR_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall[i]) begin
                            state[i]    <= IDLE;
                            hr_cnt[i]   <= '0;
                            btn_long[i] <= 1'b0;
                        end else if (hr_cnt[i] == REP_LAST) begin
                            hr_cnt[i]     <= '0;
                            btn_repeat[i] <= 1'b1;
                        end else begin
                            hr_cnt[i] <= hr_cnt[i] + HR_W'(1);
                        end
                    end
                    default: begin
                        state[i]    <= IDLE;
                        hr_cnt[i]   <= '0;
                        btn_long[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: scoreboard bench for btn_cond with a small-clock parameter set.
// Every driven cycle pushes the model's expected outputs; a monitor pops and
// compares them after each rising edge.
module tb_btn_cond;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic [N-1:0] btn_long;

    always #5 clk = ~clk;

    btn_cond #(
        .CLK_FREQ   (1000),
        .N_BTN      (N),
        .DEBOUNCE_MS(4),
        .HOLD_MS    (20),
        .REPEAT_MS  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_long   (btn_long)
    );

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
        logic [N-1:0] lng;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int cur_edge = 0;

    int press_cnt [N];
    int rel_cnt   [N];
    int rep_cnt   [N];
    int press_edge[N];

    // Reference model state: the two raw samples in flight through the
    // synchronizer, the clean level, how many consecutive edges the
    // synchronized value has disagreed with it, and when the press happened.
    logic m_s0 [N];
    logic m_s1 [N];
    logic m_lvl[N];
    int   m_run[N];
    int   m_pt [N];

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Expected outputs right after edge e, given what that edge samples.
    task automatic model_edge(input logic r, input logic [N-1:0] raw, input int e);
        exp_t x;
        logic sv;
        int   d;
        x = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                m_s0[c]  = 1'b0;
                m_s1[c]  = 1'b0;
                m_lvl[c] = 1'b0;
                m_run[c] = 0;
            end else begin
                sv      = m_s1[c];
                m_s1[c] = m_s0[c];
                m_s0[c] = raw[c];
                if (sv != m_lvl[c]) m_run[c]++;
                else                m_run[c] = 0;
                // Disagreement lasting DB+1 edges commits the new level.
                if (m_run[c] == DB + 1) begin
                    m_lvl[c] = sv;
                    m_run[c] = 0;
                    if (sv) begin
                        x.prs[c] = 1'b1;
                        m_pt[c]  = e;
                    end else begin
                        x.rel[c] = 1'b1;
                    end
                end
                x.lvl[c] = m_lvl[c];
                if (m_lvl[c]) begin
                    d = e - m_pt[c];
                    if (d >= HOLD) begin
                        x.lng[c] = 1'b1;
                        if ((d - HOLD) % REP == 0) x.rep[c] = 1'b1;
                    end
                end
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic [N-1:0] raw);
        @(negedge clk);
        rst      = r;
        btn_raw  = raw;
        cur_edge = edge_cnt;
        model_edge(r, raw, edge_cnt);
    endtask

    // Monitor: one expectation per driven edge.
    initial begin
        for (int c = 0; c < N; c++) begin
            press_cnt[c]  = 0;
            rel_cnt[c]    = 0;
            rep_cnt[c]    = 0;
            press_edge[c] = -1;
        end
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                check("btn_level",   btn_level,   mon_x.lvl);
                check("btn_press",   btn_press,   mon_x.prs);
                check("btn_release", btn_release, mon_x.rel);
                check("btn_repeat",  btn_repeat,  mon_x.rep);
                check("btn_long",    btn_long,    mon_x.lng);
                for (int c = 0; c < N; c++) begin
                    if (btn_press[c] === 1'b1) begin
                        press_cnt[c]++;
                        press_edge[c] = edge_cnt;
                    end
                    if (btn_release[c] === 1'b1) rel_cnt[c]++;
                    if (btn_repeat[c] === 1'b1)  rep_cnt[c]++;
                end
            end
            edge_cnt++;
        end
    end

    initial begin
        int t0, ts, tr, pc0, pc1, rc0, rc1, ec0, ec1;
        logic [N-1:0] v;
        int len;

        for (int c = 0; c < N; c++) begin
            m_s0[c] = 1'b0; m_s1[c] = 1'b0; m_lvl[c] = 1'b0;
            m_run[c] = 0;   m_pt[c] = 0;
        end

        repeat (3) step(1'b1, 2'b00);
        repeat (3) step(1'b0, 2'b00);

        // Clean press held long enough for four repeats, then released.
        pc0 = press_cnt[0]; pc1 = press_cnt[1]; rc0 = rel_cnt[0]; ec0 = rep_cnt[0];
        step(1'b0, 2'b01);
        t0 = cur_edge;
        repeat (39) step(1'b0, 2'b01);
        repeat (12) step(1'b0, 2'b00);
        check_int("clean_press_edge", press_edge[0], t0 + 6);
        check_int("clean_press_count", press_cnt[0] - pc0, 1);
        check_int("clean_other_press", press_cnt[1] - pc1, 0);
        check_int("long_repeat_count", rep_cnt[0] - ec0, 4);
        check_int("long_release_count", rel_cnt[0] - rc0, 1);

        // Bouncing contact: toggles every 2 cycles, then settles high.
        pc0 = press_cnt[0]; rc0 = rel_cnt[0];
        for (int k = 0; k < 12; k++) step(1'b0, ((k / 2) % 2 == 0) ? 2'b01 : 2'b00);
        step(1'b0, 2'b01);
        ts = cur_edge;
        repeat (15) step(1'b0, 2'b01);
        check_int("bounce_press_count", press_cnt[0] - pc0, 1);
        check_int("bounce_press_edge", press_edge[0], ts + 6);
        check_int("bounce_release_count", rel_cnt[0] - rc0, 0);
        repeat (12) step(1'b0, 2'b00);

        // Short glitch on channel 1.
        pc1 = press_cnt[1]; rc1 = rel_cnt[1];
        repeat (3) step(1'b0, 2'b10);
        repeat (12) step(1'b0, 2'b00);
        check_int("glitch_press_count", press_cnt[1] - pc1, 0);
        check_int("glitch_release_count", rel_cnt[1] - rc1, 0);

        // Both channels pressed on the same edge.
        ec0 = rep_cnt[0]; ec1 = rep_cnt[1];
        step(1'b0, 2'b11);
        ts = cur_edge;
        repeat (39) step(1'b0, 2'b11);
        repeat (12) step(1'b0, 2'b00);
        check_int("simul_press_edge0", press_edge[0], ts + 6);
        check_int("simul_press_edge1", press_edge[1], ts + 6);
        check_int("simul_repeat0", rep_cnt[0] - ec0, 4);
        check_int("simul_repeat1", rep_cnt[1] - ec1, 4);

        // Reset in the middle of a hold, button kept down.
        rc0 = rel_cnt[0];
        step(1'b0, 2'b01);
        repeat (30) step(1'b0, 2'b01);
        step(1'b1, 2'b01);
        tr = cur_edge;
        repeat (15) step(1'b0, 2'b01);
        check_int("rst_hold_release_count", rel_cnt[0] - rc0, 0);
        check_int("rst_repress_edge", press_edge[0], tr + 7);
        repeat (12) step(1'b0, 2'b00);

        // Randomized segments with contact noise and occasional reset.
        for (int s = 0; s < 80; s++) begin
            v   = N'($urandom);
            len = $urandom_range(1, 50);
            for (int k = 0; k < len; k++) begin
                logic [N-1:0] noisy;
                noisy = v;
                if ($urandom_range(0, 9) == 0) noisy = noisy ^ N'($urandom);
                step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, noisy);
            end
        end
        repeat (12) step(1'b0, 2'b00);

        // Drain: let the monitor consume the last expectation.
        repeat (3) @(posedge clk);
        #2;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter N_BTN, default 5, is the number of independent button channels.
REQ-003 Parameter DEBOUNCE_MS, default 10, is the debounce settle time in ms.
REQ-004 Parameter HOLD_MS, default 500, is the long-press threshold in ms.
REQ-005 Parameter REPEAT_MS, default 100, is the auto-repeat period in ms.
REQ-006 clk  input  1  is the single system clock; all state SHALL be on its rising edge.
REQ-007 rst  input  1  is the reset, synchronous and active-high.
REQ-008 btn_raw  input  N_BTN  carries the asynchronous, bouncing push-button levels, active-high.
REQ-009 btn_level  output  N_BTN  carries the debounced button level.
REQ-010 btn_press  output  N_BTN  carries a one-cycle pulse on each debounced rising edge.
REQ-011 btn_release  output  N_BTN  carries a one-cycle pulse on each debounced falling edge.
REQ-012 btn_repeat  output  N_BTN  carries one-cycle auto-repeat pulses while a button is held.
REQ-013 btn_long  output  N_BTN  is high while a button has been held for at least HOLD_MS.

Function
REQ-014 Derived constants SHALL be fixed at elaboration: DB_CYC=CLK_FREQ/1000*DEBOUNCE_MS, HOLD_CYC=CLK_FREQ/1000*HOLD_MS, REP_CYC=CLK_FREQ/1000*REPEAT_MS; each SHALL be >=1, and elaboration SHALL fail otherwise.
REQ-015 Counter widths SHALL be $clog2 of the corresponding constant plus 1, and counters SHALL saturate or clear, never wrap.
REQ-016 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Debounce, per channel:
- A counter increments each cycle the synchronized value differs from btn_level.
- The counter clears in any cycle they are equal.
- When the count reaches DB_CYC, btn_level takes the synchronized value and the counter clears.
REQ-018 A clean raw transition SHALL appear on btn_level exactly DB_CYC+2 cycles after the first clk edge that samples the new raw value.
REQ-019 A raw pulse or glitch shorter than DB_CYC cycles after synchronization SHALL produce no output change.
REQ-020 btn_press SHALL be high for exactly the first cycle btn_level is 1, and btn_release for exactly the first cycle btn_level is 0 after being 1.
REQ-021 Hold FSM, per channel, with states IDLE, HELD and REPEAT:
- IDLE moves to HELD on a press; the hold counter clears.
- HELD counts cycles; HOLD_CYC cycles after the btn_press cycle it pulses btn_repeat, raises btn_long and moves to REPEAT with the counter cleared.
- REPEAT pulses btn_repeat every REP_CYC cycles.
REQ-022 On a debounced release in HELD or REPEAT, the FSM SHALL return to IDLE and btn_long SHALL drop in the btn_release cycle.
REQ-023 A repeat pulse falling in the btn_release cycle SHALL be suppressed (release wins).
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own outputs in the same cycles.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst is sampled high, synchronizer flops, btn_level, all counters and all outputs SHALL clear to 0, and every FSM SHALL enter IDLE; outputs read 0 from the cycle after the rst edge.
REQ-027 Reset mid-hold SHALL abort the hold without a btn_release pulse.
REQ-028 A button still high at rst deassertion SHALL be treated as a new press, with btn_press issued DB_CYC+2 cycles later.

Verification (CLK_FREQ=1000, N_BTN=2, DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5; cycle numbers relative to the first edge sampling the raw change)
REQ-029 Clean press: btn_raw[0] goes 0->1 and holds -> btn_level[0] rises at cycle 6, with a single btn_press[0] pulse at cycle 6 and btn_raw[1] outputs staying 0.
REQ-030 Bounce: btn_raw[0] toggles every 2 cycles for 12 cycles, then settles high -> exactly one btn_press[0], 6 cycles after the final settle, and no btn_release.
REQ-031 Long hold: press with btn_press at P, raw held until btn_level falls at P+40 -> btn_long rises at P+20; btn_repeat pulses at P+20, P+25, P+30 and P+35; P+40 repeat is suppressed; btn_release and btn_long fall at P+40.
REQ-032 Glitch: a 3-cycle high pulse on btn_raw[1] -> all outputs stay 0.
REQ-033 Simultaneous: both raw bits rise on the same edge -> both btn_press pulses occur in the same cycle, and each hold sequence matches REQ-031 independently.
REQ-034 Reset mid-hold: a 1-cycle rst at P+25 with raw held high -> all outputs 0 the cycle after and no btn_release; btn_press re-fires 6 cycles after rst deassertion.
